// File: rtl/micro_div_njp.sv
// micro_div_njp: sequential restoring divider, one quotient bit per clock.
// Unsigned WIDTH-bit dividend/divisor in; WIDTH-bit quotient and remainder out,
// plus a divide-by-zero flag. Results are registered and held until the next
// accepted request reaches its DONE cycle.
module micro_div_njp #(
  parameter int WIDTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Working registers. R is one bit wider than the operands so the shifted
  // partial remainder never loses its carry-out before the trial subtract.
  logic [WIDTH-1:0] d_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] t_diff;
  logic             t_neg;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last_iter;

  // One restoring step: shift {R,Q} left, trial-subtract D, keep or restore.
  always_comb begin
    r_sh      = {r_q, q_q[WIDTH-1]};
    t_diff    = r_sh - {2'b00, d_q};
    t_neg     = t_diff[WIDTH+1];
    r_nxt     = t_neg ? r_sh[WIDTH:0] : t_diff[WIDTH:0];
    q_nxt     = (q_q << 1) | WIDTH'(!t_neg);
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : ITER;
      ITER: if (last_iter) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath and result registers; results load only on the edge entering DONE.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      d_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d_q <= divisor;
            r_q <= '0;
            q_q <= dividend;
            cnt <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        ITER: begin
          r_q <= r_nxt;
          q_q <= q_nxt;
          cnt <= cnt + CW'(1);
          if (last_iter) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
